// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: opcodes, instruction fields
// and the fetch/execute sequencer state encoding.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int IMM_BIT = 12;
    localparam int RX_MSB  = 11;
    localparam int RX_LSB  = 9;
    localparam int RY_MSB  = 2;
    localparam int RY_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_MEM,
        ST_DECODE,
        ST_EXEC,
        ST_HALTED,
        ST_ERROR
    } seq_state_t;

    function automatic logic [2:0] opcode_of(input logic [15:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory and control-unit handshake bundle driven by the sequencer.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;
    logic [15:0]       instr;
    logic              run;
    logic              done;

    modport master (
        output mem_addr, mem_rd, instr, run,
        input  mem_rdata, done
    );

    modport slave (
        input  mem_addr, mem_rd, instr, run,
        output mem_rdata, done
    );
endinterface

// File: rtl/instr_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches 16-bit instructions, hands them to the
// control unit via run/done, and stops on HALT, stop request or timeout.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop_req,
    instr_sequencer_if.master bus,
    output logic              halted,
    output logic              error,
    output logic [15:0]       retired
);
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    seq_state_t        state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic              mem_rd_d, mem_rd_q;
    logic [15:0]       instr_d, instr_q;
    logic              run_d, run_q;
    logic              halted_d, halted_q;
    logic              error_d, error_q;
    logic              stop_d, stop_q;
    logic [TO_W-1:0]   tmo_d, tmo_q;
    logic              start_acc;
    logic              retire;

    // All outputs are registered; each state sets up the outputs of the next one.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        instr_d    = instr_q;
        run_d      = 1'b0;
        halted_d   = halted_q;
        error_d    = error_q;
        stop_d     = stop_q;
        tmo_d      = tmo_q;
        start_acc  = 1'b0;
        retire     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) begin
                    start_acc  = 1'b1;
                    pc_d       = start_addr;
                    halted_d   = 1'b0;
                    error_d    = 1'b0;
                    stop_d     = 1'b0;
                    mem_addr_d = start_addr;
                    mem_rd_d   = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                stop_d  = stop_q | stop_req;
                state_d = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                stop_d  = stop_q | stop_req;
                instr_d = bus.mem_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                stop_d = stop_q | stop_req;
                if (opcode_of(instr_q) == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    tmo_d   = '0;
                    run_d   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                stop_d = stop_q | stop_req;
                if (bus.done) begin
                    retire = 1'b1;
                    if (stop_q) begin
                        stop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        mem_addr_d = pc_q;
                        mem_rd_d   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end else if (tmo_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    run_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            instr_q    <= 16'h0000;
            run_q      <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
            stop_q     <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            instr_q    <= instr_d;
            run_q      <= run_d;
            halted_q   <= halted_d;
            error_q    <= error_d;
            stop_q     <= stop_d;
            tmo_q      <= tmo_d;
        end
    end

    sat_counter #(.W(16)) u_retired (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (start_acc),
        .inc   (retire),
        .cnt   (retired)
    );

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.instr    = instr_q;
    assign bus.run      = run_q;
    assign halted       = halted_q;
    assign error        = error_q;
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/execute sequencer for the multicycle processor.
- Reads 16-bit instructions from a synchronous instruction memory at a program counter and presents each one on the instruction bus.
- Drives the control unit's `run` line so the control unit captures the instruction in T0 and executes it.
- Waits for the control unit's `done`, then advances the PC.
- Stops on a HALT opcode, on a stop request, or on an execution timeout.

## Interface
Parameters:
- ADDR_W, 8, PC / memory address width
- TIMEOUT, 16, max EXEC cycles without `done` before ERROR (≥ 4)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; accepted only in IDLE, HALTED or ERROR
- start_addr  in  ADDR_W  PC loaded when start is accepted
- stop_req  in  1  level; stop after the current instruction retires
- mem_addr  out  ADDR_W  instruction memory address
- mem_rd  out  1  memory read strobe; data is valid the following cycle
- mem_rdata  in  16  instruction memory read data
- instr  out  16  instruction bus to the IR
- run  out  1  to the control unit; low forces it to T0
- done  in  1  control unit instruction-complete
- halted  out  1  high in HALTED
- error  out  1  high in ERROR
- retired  out  16  retired-instruction count, saturates at 16'hFFFF

## Operation
- States: IDLE, FETCH, WAIT_MEM, DECODE, EXEC, HALTED, ERROR.
- Reset values:
  - state = IDLE
  - pc = 0, mem_addr = 0, mem_rd = 0
  - instr = 16'h0000
  - run = 0
  - halted = 0, error = 0
  - retired = 0
  - stop latch cleared
- IDLE/HALTED/ERROR + start:
  - pc ← start_addr
  - retired ← 0
  - halted, error, stop latch cleared
  - go to FETCH
- FETCH: mem_addr = pc, mem_rd = 1 → WAIT_MEM.
- WAIT_MEM: instr ← mem_rdata at the cycle end → DECODE.
- DECODE:
  - instr[15:13] == 3'b111 (HALT) → HALTED; pc is not incremented; not counted as retired.
  - Otherwise: run = 0 for this cycle, pc ← pc + 1 (mod 2^ADDR_W, wraps from all-ones to 0), timeout counter ← 0 → EXEC.
- EXEC:
  - run = 1; instr is held stable for the whole state.
  - `done` sampled high → retired increments (saturating), then:
    - if the stop latch is set → IDLE;
    - otherwise → FETCH.
  - Timeout counter reaches TIMEOUT−1 with `done` low → ERROR, run = 0.
- Stop request:
  - stop_req is latched in any running state (FETCH…EXEC) and cleared on entry to IDLE.
  - stop_req asserted in FETCH/WAIT_MEM/DECODE still lets that instruction execute fully.
- `done` outside EXEC is ignored.
- start outside IDLE/HALTED/ERROR is ignored.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately.
  - run drops to 0, so the control unit returns to T0 on its next edge.

## Timing
Start latency, with start sampled at edge 0:
- FETCH in cycle 1
- WAIT_MEM in cycle 2
- DECODE in cycle 3 (run = 0)
- EXEC from cycle 4

Per instruction:
- Sequencer overhead is 3 cycles (FETCH + WAIT_MEM + DECODE) plus the EXEC cycles up to and including the `done` cycle.
- The control unit enters T0 at the edge ending DECODE and loads the IR from `instr` during the first EXEC cycle.
- MV/MVT: `done` in the 3rd EXEC cycle.
- ADD/SUB/AND: `done` in the 5th EXEC cycle.
- Example: a MV takes 6 cycles from FETCH to the next FETCH.

Other timing rules:
- run is registered; there is no combinational path from `done` to run.
- mem_rd is high exactly one cycle per fetch.

## Structure
Shared package `proc_pkg` holds:
- Opcode constants (MV, MVT, ADD, SUB, AND, HALT = 3'b111)
- Field positions (opcode [15:13], imm [12], RX [11:9], RY [2:0])
- The sequencer state encoding

Sub-module `sat_counter` (width, saturating increment, sync clear) is used for `retired`.
- The timeout counter is an inline counter.

## Test plan
- Reset, then start with start_addr = 8'h10; memory holds MV at 10, ADD at 11, HALT at 12.
  - → mem_addr sequence 10, 11, 12; run low exactly one cycle before each EXEC; halted = 1; retired = 2; pc = 12.
- start_addr = 8'hFF with a MV at FF and HALT at 00.
  - → PC wraps; second fetch address is 00; retired = 1.
- Control unit model never asserts `done` after DECODE.
  - → ERROR after 16 EXEC cycles; error = 1; run = 0; a following start clears error.
- stop_req pulsed in the WAIT_MEM cycle of instruction 2.
  - → instruction 2 completes; state returns to IDLE; no third fetch; retired = 2.
- reset_n dropped asynchronously during EXEC of an ADD.
  - → run, mem_rd and retired are 0 before the next edge; state is IDLE.
- Preload retired = 16'hFFFE (force), then retire 3 instructions.
  - → retired stays 16'hFFFF.
